decode_cycle: RTL

- Decode stage of the 5-stage RV32I pipeline. Sits directly downstream of the fetch stage and consumes its InstrD, PCD and PCPlus4D outputs.
- Holds the 32x32 register file, main and ALU decoders, and immediate extender.
- Registers all decoded control and data into the ID/EX pipeline register that feeds the execute stage.
- Accepts writeback from the W stage and a flush request from the hazard unit.

---
 rtl/decode_cycle.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with register file, control decoders, immediate extender and ID/EX register
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);
  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      alu_ctrl;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } idex_t;

  logic [XLEN-1:0] rf_q [NREGS];
  idex_t           idex_q, idex_d;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2;
  logic            reg_write, alu_src, mem_write, branch, jump;
  logic [1:0]      imm_src, result_src, alu_op;
  logic [2:0]      alu_ctrl;
  logic [XLEN-1:0] imm_ext;
  logic            byp1, byp2;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];

  always_comb begin
    {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump} = 11'b0;
    case (opcode)
      7'b0000011: {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump} = 11'b1_00_1_0_01_0_00_0;
      7'b0100011: {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump} = 11'b0_01_1_1_00_0_00_0;
      7'b0110011: {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump} = 11'b1_00_0_0_00_0_10_0;
      7'b1100011: {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump} = 11'b0_10_0_0_00_1_01_0;
      7'b0010011: {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump} = 11'b1_00_1_0_00_0_10_0;
      7'b1101111: {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump} = 11'b1_11_0_0_10_0_00_1;
      default:    {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump} = 11'b0;
    endcase
  end

  always_comb begin
    alu_ctrl = 3'b000;
    if (alu_op == 2'b01) alu_ctrl = 3'b001;
    else if (alu_op == 2'b10)
      case (funct3)
        3'b000:  alu_ctrl = (opcode[5] && InstrD[30]) ? 3'b001 : 3'b000;
        3'b010:  alu_ctrl = 3'b101;
        3'b110:  alu_ctrl = 3'b011;
        3'b111:  alu_ctrl = 3'b010;
        default: alu_ctrl = 3'b000;
      endcase
  end

  always_comb begin
    case (imm_src)
      2'b00:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      2'b01:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    endcase
  end

  // A register being written this cycle is forwarded so decode never reads stale data
  assign byp1 = RegWriteW && (RdW != 5'd0) && (RdW == rs1);
  assign byp2 = RegWriteW && (RdW != 5'd0) && (RdW == rs2);

  always_comb begin
    idex_d            = '0;
    idex_d.reg_write  = reg_write;
    idex_d.result_src = result_src;
    idex_d.mem_write  = mem_write;
    idex_d.jump       = jump;
    idex_d.branch     = branch;
    idex_d.alu_ctrl   = alu_ctrl;
    idex_d.alu_src    = alu_src;
    idex_d.rd1        = (rs1 == 5'd0) ? '0 : byp1 ? ResultW : rf_q[rs1];
    idex_d.rd2        = (rs2 == 5'd0) ? '0 : byp2 ? ResultW : rf_q[rs2];
    idex_d.imm        = imm_ext;
    idex_d.rs1        = rs1;
    idex_d.rs2        = rs2;
    idex_d.rd         = InstrD[11:7];
    idex_d.pc         = PCD;
    idex_d.pc4        = PCPlus4D;
  end

  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    else if (RegWriteW && RdW != 5'd0) rf_q[RdW] <= ResultW;
  end

  always_ff @(posedge clk) begin
    if (rst || FlushE) idex_q <= '0;
    else idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign ResultSrcE  = idex_q.result_src;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUControlE = idex_q.alu_ctrl;
  assign ALUSrcE     = idex_q.alu_src;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;
endmodule
